// File: rtl/multicycle_ctrl_if.sv
// Control/datapath bundle for the multicycle core controller.
// Perf counter members exist only when PERF_COUNT_EN is defined.
interface multicycle_ctrl_if #(
   parameter int INSTR_W = 9
);
   logic               start;
   logic [INSTR_W-1:0] instr;
   logic               br_cond;
   logic               mem_ack;
   logic [1:0]         state_o;
   logic [INSTR_W-1:0] ir_o;
   logic [2:0]         alu_op;
   logic               rf_rd_en;
   logic               rf_wr_en;
   logic               wb_sel;
   logic               mem_rd;
   logic               mem_wr;
   logic               pc_en;
   logic               pc_branch;
   logic               running;
   logic               done;
   logic               mem_err;
`ifdef PERF_COUNT_EN
   logic [31:0]        cycle_cnt;
   logic [31:0]        instr_cnt;
`endif

   // mem_rd/mem_wr stay asserted in DATAMEM until the cycle mem_ack is seen high.
   modport master (
      input  start, instr, br_cond, mem_ack,
      output state_o, ir_o, alu_op, rf_rd_en, rf_wr_en, wb_sel, mem_rd, mem_wr,
             pc_en, pc_branch, running, done, mem_err
`ifdef PERF_COUNT_EN
      , cycle_cnt, instr_cnt
`endif
   );

   modport slave (
      output start, instr, br_cond, mem_ack,
      input  state_o, ir_o, alu_op, rf_rd_en, rf_wr_en, wb_sel, mem_rd, mem_wr,
             pc_en, pc_branch, running, done, mem_err
`ifdef PERF_COUNT_EN
      , cycle_cnt, instr_cnt
`endif
   );
endinterface

// File: rtl/multicycle_ctrl.sv
// Four-phase control FSM of the multicycle 9-bit core with run/halt and memory timeout.
// Optional macro PERF_COUNT_EN adds cycle_cnt/instr_cnt performance counters.
module multicycle_ctrl #(
   parameter int                 INSTR_W      = 9,
   parameter logic [INSTR_W-1:0] HALT_INSTR   = 9'h1FF,
   parameter int                 MEM_WAIT_MAX = 15
) (
   input logic               clk,
   input logic               rst_n,
   multicycle_ctrl_if.master bus
);
   typedef enum logic [1:0] {
      ST_PC            = 2'd0,
      ST_REGISTERREAD  = 2'd1,
      ST_DATAMEM       = 2'd2,
      ST_REGISTERWRITE = 2'd3
   } state_t;

   localparam logic [2:0] OP_LD   = 3'b101;
   localparam logic [2:0] OP_ST   = 3'b110;
   localparam logic [2:0] OP_BLQZ = 3'b111;
   localparam int         WAIT_W  = $clog2(MEM_WAIT_MAX + 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_WAIT_MAX);

   state_t             state_q, state_d;
   logic [INSTR_W-1:0] ir_q, ir_d;
   logic               running_q, running_d;
   logic               done_q, done_d;
   logic               mem_err_q, mem_err_d;
   logic [WAIT_W-1:0]  wait_q, wait_d;

   logic       rf_rd_en, rf_wr_en, wb_sel, mem_rd, mem_wr, pc_en, pc_branch;
   logic       start_accept;
   logic [2:0] opcode;

   assign opcode = ir_q[INSTR_W-1 -: 3];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_PC;
         ir_q      <= '0;
         running_q <= 1'b0;
         done_q    <= 1'b0;
         mem_err_q <= 1'b0;
         wait_q    <= '0;
      end else begin
         state_q   <= state_d;
         ir_q      <= ir_d;
         running_q <= running_d;
         done_q    <= done_d;
         mem_err_q <= mem_err_d;
         wait_q    <= wait_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      ir_d         = ir_q;
      running_d    = running_q;
      done_d       = done_q;
      mem_err_d    = mem_err_q;
      wait_d       = wait_q;
      rf_rd_en     = 1'b0;
      rf_wr_en     = 1'b0;
      wb_sel       = 1'b0;
      mem_rd       = 1'b0;
      mem_wr       = 1'b0;
      pc_en        = 1'b0;
      pc_branch    = 1'b0;
      start_accept = 1'b0;

      case (state_q)
         ST_PC: begin
            if (!running_q) begin
               if (bus.start) begin
                  start_accept = 1'b1;
                  running_d    = 1'b1;
                  done_d       = 1'b0;
                  mem_err_d    = 1'b0;
               end
            // The halt encoding is recognised before it would be latched as an instruction.
            end else if (bus.instr == HALT_INSTR) begin
               running_d = 1'b0;
               done_d    = 1'b1;
            end else begin
               ir_d    = bus.instr;
               state_d = ST_REGISTERREAD;
            end
         end
         ST_REGISTERREAD: begin
            rf_rd_en = 1'b1;
            case (opcode)
               OP_LD, OP_ST: begin
                  state_d = ST_DATAMEM;
                  wait_d  = '0;
               end
               OP_BLQZ: begin
                  pc_en     = 1'b1;
                  pc_branch = bus.br_cond;
                  state_d   = ST_PC;
               end
               default: state_d = ST_REGISTERWRITE;
            endcase
         end
         ST_DATAMEM: begin
            mem_rd = (opcode == OP_LD);
            mem_wr = (opcode == OP_ST);
            // An ack arriving in the last allowed wait cycle still wins over the timeout.
            if (bus.mem_ack) begin
               if (opcode == OP_LD) begin
                  state_d = ST_REGISTERWRITE;
               end else begin
                  pc_en   = 1'b1;
                  state_d = ST_PC;
               end
            end else if (wait_q == WAIT_LAST) begin
               mem_err_d = 1'b1;
               running_d = 1'b0;
               state_d   = ST_PC;
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end
         ST_REGISTERWRITE: begin
            rf_wr_en = 1'b1;
            wb_sel   = (opcode == OP_LD);
            pc_en    = 1'b1;
            state_d  = ST_PC;
         end
         default: state_d = ST_PC;
      endcase
   end

`ifdef PERF_COUNT_EN
   logic [31:0] cycle_cnt_q, instr_cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cycle_cnt_q <= '0;
         instr_cnt_q <= '0;
      end else if (start_accept) begin
         cycle_cnt_q <= '0;
         instr_cnt_q <= '0;
      end else begin
         if (running_q) cycle_cnt_q <= cycle_cnt_q + 32'd1;
         if (pc_en)     instr_cnt_q <= instr_cnt_q + 32'd1;
      end
   end

   assign bus.cycle_cnt = cycle_cnt_q;
   assign bus.instr_cnt = instr_cnt_q;
`endif

   assign bus.state_o   = state_q;
   assign bus.ir_o      = ir_q;
   assign bus.alu_op    = opcode;
   assign bus.rf_rd_en  = rf_rd_en;
   assign bus.rf_wr_en  = rf_wr_en;
   assign bus.wb_sel    = wb_sel;
   assign bus.mem_rd    = mem_rd;
   assign bus.mem_wr    = mem_wr;
   assign bus.pc_en     = pc_en;
   assign bus.pc_branch = pc_branch;
   assign bus.running   = running_q;
   assign bus.done      = done_q;
   assign bus.mem_err   = mem_err_q;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: each instruction is expanded into its expected phase
// sequence from the instruction-class rules, and every cycle is checked against it.
module tb_multicycle_ctrl;
   localparam int         MAX  = 15;
   localparam logic [8:0] HALT = 9'h1FF;
   localparam logic [1:0] P_PC = 2'd0, P_RR = 2'd1, P_DM = 2'd2, P_RW = 2'd3;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   multicycle_ctrl_if bus ();

   multicycle_ctrl dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int vectors     = 0;
   int miscompares = 0;

   // architectural model state
   logic [8:0] ir_m;
   logic       run_m, done_m, err_m;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      assert (act === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   task automatic drive(input logic st, input logic [8:0] ins, input logic br, input logic ack);
      @(negedge clk);
      bus.start   = st;
      bus.instr   = ins;
      bus.br_cond = br;
      bus.mem_ack = ack;
      #1;
   endtask

   function automatic logic rb();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic logic [8:0] r9();
      return 9'($urandom_range(0, 511));
   endfunction

   task automatic expect_cycle(input logic [1:0] ph, input logic rd, input logic wr,
                               input logic wb, input logic mrd, input logic mwr,
                               input logic pce, input logic pcb);
      chk("state_o",   32'(bus.state_o),   32'(ph));
      chk("ir_o",      32'(bus.ir_o),      32'(ir_m));
      chk("alu_op",    32'(bus.alu_op),    32'(ir_m[8:6]));
      chk("rf_rd_en",  32'(bus.rf_rd_en),  32'(rd));
      chk("rf_wr_en",  32'(bus.rf_wr_en),  32'(wr));
      chk("wb_sel",    32'(bus.wb_sel),    32'(wb));
      chk("mem_rd",    32'(bus.mem_rd),    32'(mrd));
      chk("mem_wr",    32'(bus.mem_wr),    32'(mwr));
      chk("pc_en",     32'(bus.pc_en),     32'(pce));
      chk("pc_branch", 32'(bus.pc_branch), 32'(pcb));
      chk("running",   32'(bus.running),   32'(run_m));
      chk("done",      32'(bus.done),      32'(done_m));
      chk("mem_err",   32'(bus.mem_err),   32'(err_m));
   endtask

   task automatic idle_cycle();
      drive(1'b0, r9(), rb(), rb());
      expect_cycle(P_PC, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic do_start();
      drive(1'b1, r9(), rb(), rb());
      expect_cycle(P_PC, 0, 0, 0, 0, 0, 0, 0);
      run_m  = 1'b1;
      done_m = 1'b0;
      err_m  = 1'b0;
   endtask

   // w = number of DATAMEM cycles without ack before the ack; w > MAX means no ack at all
   task automatic do_instr(input logic [8:0] ins, input int w, input logic br);
      logic [2:0] op;
      logic       is_ld, is_st, ack;
      op    = ins[8:6];
      is_ld = (op == 3'b101);
      is_st = (op == 3'b110);
      drive(rb(), ins, rb(), rb());
      expect_cycle(P_PC, 0, 0, 0, 0, 0, 0, 0);
      if (ins == HALT) begin
         run_m  = 1'b0;
         done_m = 1'b1;
         return;
      end
      ir_m = ins;
      drive(rb(), r9(), br, rb());
      expect_cycle(P_RR, 1, 0, 0, 0, 0, op == 3'b111, (op == 3'b111) && br);
      if (op == 3'b111) return;
      if (is_ld || is_st) begin
         for (int k = 0; k <= MAX; k++) begin
            ack = (k == w);
            drive(rb(), r9(), rb(), ack);
            expect_cycle(P_DM, 0, 0, 0, is_ld, is_st, ack && is_st, 0);
            if (ack) begin
               if (is_st) return;
               break;
            end
            if (k == MAX) begin
               err_m = 1'b1;
               run_m = 1'b0;
               return;
            end
         end
      end
      drive(rb(), r9(), rb(), rb());
      expect_cycle(P_RW, 0, 1, is_ld, 0, 0, 1, 0);
   endtask

   initial begin
      logic [8:0] ins;
      ir_m   = '0;
      run_m  = 1'b0;
      done_m = 1'b0;
      err_m  = 1'b0;
      rst_n       = 1'b0;
      bus.start   = 1'b0;
      bus.instr   = '0;
      bus.br_cond = 1'b0;
      bus.mem_ack = 1'b0;
      #12;
      expect_cycle(P_PC, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      rst_n = 1'b1;

      idle_cycle();
      idle_cycle();
      do_start();
      do_instr(9'h000, 0, 1'b0);            // ADD
      do_instr(9'b001_010_011, 0, 1'b1);    // XOR
      do_instr(9'b101_000_000, 2, 1'b0);    // LD, two wait cycles
      do_instr(9'b111_000_000, 0, 1'b1);    // BLQZ taken
      do_instr(9'b111_000_000, 0, 1'b0);    // BLQZ not taken
      do_instr(9'b110_001_001, 0, 1'b0);    // ST, immediate ack
      do_instr(9'b101_011_000, MAX, 1'b0);  // LD, ack on last allowed cycle
      do_instr(9'b110_000_000, MAX + 1, 1'b0); // ST timeout
      idle_cycle();
      do_start();                           // clears mem_err
      do_instr(9'h000, 0, 1'b0);
      do_instr(9'h000, 0, 1'b0);
      do_instr(HALT, 0, 1'b0);
      idle_cycle();
      idle_cycle();
      do_start();                           // clears done
      do_instr(9'b100_110_001, 0, 1'b0);    // MOV

      for (int n = 0; n < 40; n++) begin
         if (!run_m) begin
            idle_cycle();
            do_start();
         end
         ins = r9();
         if ($urandom_range(0, 9) == 0) ins = HALT;
         do_instr(ins, $urandom_range(0, MAX + 2), rb());
      end

      // reset in the middle of a store's DATAMEM phase
      if (!run_m) do_start();
      ins = 9'b110_010_101;
      drive(1'b0, ins, rb(), 1'b0);
      expect_cycle(P_PC, 0, 0, 0, 0, 0, 0, 0);
      ir_m = ins;
      drive(1'b0, r9(), rb(), 1'b0);
      expect_cycle(P_RR, 1, 0, 0, 0, 0, 0, 0);
      drive(1'b0, r9(), rb(), 1'b0);
      expect_cycle(P_DM, 0, 0, 0, 0, 1, 0, 0);
      #1;
      rst_n = 1'b0;
      #1;
      ir_m   = '0;
      run_m  = 1'b0;
      done_m = 1'b0;
      err_m  = 1'b0;
      expect_cycle(P_PC, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      rst_n = 1'b1;
      idle_cycle();
      do_start();
      do_instr(9'b010_001_001, 0, 1'b0);    // AND after reset recovery

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
